// File: rtl/code_entry_fsm.sv
// Code-maker front end: shifts DIGITS symbols into a code, then offers it by valid/ack (1-cycle latency, held until ack).
// Optional CODE_NO_REPEAT_EN discards symbols already present in the current entry.
module code_entry_fsm #(
    parameter int DIGITS      = 4,
    parameter int SYM_W       = 3,
    parameter int NUM_PLAYERS = 2,
    localparam int PLAYER_W   = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
    localparam int CNT_W      = $clog2(DIGITS + 1),
    localparam int CODE_W     = DIGITS * SYM_W
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [PLAYER_W-1:0] i_player_sel,
    input  logic [SYM_W-1:0]    i_sym_in,
    input  logic                i_sym_valid,
    input  logic                i_code_ack,
    output logic [CODE_W-1:0]   o_code,
    output logic                o_code_valid,
    output logic [PLAYER_W-1:0] o_active_p,
    output logic                o_busy,
    output logic [CNT_W-1:0]    o_digit_cnt,
    output logic                o_sym_reject
);

    typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CODE_W-1:0]   r_code;
    logic [CODE_W-1:0]   w_code_nxt;
    logic [CODE_W-1:0]   w_shifted;
    logic                r_code_valid;
    logic                w_code_valid_nxt;
    logic [PLAYER_W-1:0] r_active_p;
    logic [PLAYER_W-1:0] w_active_p_nxt;
    logic [PLAYER_W-1:0] w_player_legal;
    logic [CNT_W-1:0]    r_digit_cnt;
    logic [CNT_W-1:0]    w_digit_cnt_nxt;
    logic                r_sym_reject;
    logic                w_sym_reject_nxt;
    logic                r_busy;
    logic                w_repeat;

    // A one-symbol code has no upper field to keep, so the shift degenerates to a load.
    generate
        if (DIGITS == 1) begin : g_one_digit
            assign w_shifted = i_sym_in;
        end else begin : g_multi_digit
            assign w_shifted = {r_code[CODE_W-SYM_W-1:0], i_sym_in};
        end

        if ((1 << PLAYER_W) > NUM_PLAYERS) begin : g_player_clamp
            assign w_player_legal = (i_player_sel >= PLAYER_W'(NUM_PLAYERS)) ? '0 : i_player_sel;
        end else begin : g_player_full
            assign w_player_legal = i_player_sel;
        end
    endgenerate

`ifdef CODE_NO_REPEAT_EN
    generate
        if (DIGITS > (1 << SYM_W)) begin : g_warn_unusable
            $warning("code_entry_fsm: DIGITS exceeds alphabet size, entry can never complete with unique symbols");
        end
    endgenerate

    // Filled slots sit in the low digit_cnt positions, newest symbol in slot 0.
    always_comb begin
        w_repeat = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((CNT_W'(i) < r_digit_cnt) && (r_code[i*SYM_W +: SYM_W] == i_sym_in)) begin
                w_repeat = 1'b1;
            end
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_code       <= '0;
            r_code_valid <= 1'b0;
            r_active_p   <= '0;
            r_digit_cnt  <= '0;
            r_sym_reject <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_code       <= w_code_nxt;
            r_code_valid <= w_code_valid_nxt;
            r_active_p   <= w_active_p_nxt;
            r_digit_cnt  <= w_digit_cnt_nxt;
            r_sym_reject <= w_sym_reject_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_code_nxt       = r_code;
        w_code_valid_nxt = r_code_valid;
        w_active_p_nxt   = r_active_p;
        w_digit_cnt_nxt  = r_digit_cnt;
        w_sym_reject_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt     = S_ENTRY;
                    w_code_nxt      = '0;
                    w_digit_cnt_nxt = '0;
                    w_active_p_nxt  = w_player_legal;
                end
            end
            S_ENTRY: begin
                if (i_sym_valid) begin
                    if (w_repeat) begin
                        w_sym_reject_nxt = 1'b1;
                    end else begin
                        w_code_nxt      = w_shifted;
                        w_digit_cnt_nxt = r_digit_cnt + CNT_W'(1);
                        if (r_digit_cnt == CNT_W'(DIGITS - 1)) begin
                            w_state_nxt      = S_DONE;
                            w_code_valid_nxt = 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                w_sym_reject_nxt = i_sym_valid;
                // Ack takes priority over a concurrent start; start is re-sampled in IDLE.
                if (i_code_ack) begin
                    w_state_nxt      = S_IDLE;
                    w_code_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_code       = r_code;
    assign o_code_valid = r_code_valid;
    assign o_active_p   = r_active_p;
    assign o_busy       = r_busy;
    assign o_digit_cnt  = r_digit_cnt;
    assign o_sym_reject = r_sym_reject;

endmodule

// File: tb/tb_code_entry_fsm.sv
// Bench for code_entry_fsm: queue-based reference model checked every cycle, plus directed literal checks.
module tb_code_entry_fsm;

    localparam int D1 = 4;
    localparam int S1 = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        player_sel = 1'b0;
    logic [2:0]  sym_in = '0;
    logic        sym_valid = 1'b0;
    logic        code_ack = 1'b0;
    logic [11:0] code;
    logic        code_valid;
    logic        active_p;
    logic        busy;
    logic [2:0]  digit_cnt;
    logic        sym_reject;

    logic        b_start = 1'b0;
    logic [1:0]  b_player_sel = '0;
    logic [1:0]  b_sym_in = '0;
    logic        b_sym_valid = 1'b0;
    logic        b_code_ack = 1'b0;
    logic [11:0] b_code;
    logic        b_code_valid;
    logic [1:0]  b_active_p;
    logic        b_busy;
    logic [2:0]  b_digit_cnt;
    logic        b_sym_reject;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    code_entry_fsm dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_player_sel(player_sel),
        .i_sym_in(sym_in), .i_sym_valid(sym_valid), .i_code_ack(code_ack),
        .o_code(code), .o_code_valid(code_valid), .o_active_p(active_p),
        .o_busy(busy), .o_digit_cnt(digit_cnt), .o_sym_reject(sym_reject)
    );

    code_entry_fsm #(.DIGITS(6), .SYM_W(2), .NUM_PLAYERS(3)) dut_b (
        .i_clk(clk), .i_reset(reset), .i_start(b_start), .i_player_sel(b_player_sel),
        .i_sym_in(b_sym_in), .i_sym_valid(b_sym_valid), .i_code_ack(b_code_ack),
        .o_code(b_code), .o_code_valid(b_code_valid), .o_active_p(b_active_p),
        .o_busy(b_busy), .o_digit_cnt(b_digit_cnt), .o_sym_reject(b_sym_reject)
    );

    // Reference model: mode 0 waiting, 1 collecting, 2 code offered.
    int          m_mode = 0;
    int          q[$];
    logic [11:0] m_code = '0;
    logic        m_player = 1'b0;
    logic        m_reject = 1'b0;

    function automatic logic [11:0] pack_q();
        int v = 0;
        foreach (q[i]) v = v * (1 << S1) + q[i];
        return v[11:0];
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_mode = 0; q.delete(); m_code = '0; m_player = 1'b0; m_reject = 1'b0;
            end else begin
                m_reject = 1'b0;
                if (m_mode == 0) begin
                    if (start) begin
                        m_mode = 1; q.delete(); m_code = '0; m_player = player_sel;
                    end
                end else if (m_mode == 1) begin
                    if (sym_valid) begin
                        bit rep = 1'b0;
`ifdef CODE_NO_REPEAT_EN
                        foreach (q[i]) if (q[i] == int'(sym_in)) rep = 1'b1;
`endif
                        if (rep) begin
                            m_reject = 1'b1;
                        end else begin
                            q.push_back(int'(sym_in));
                            m_code = pack_q();
                            if (q.size() == D1) m_mode = 2;
                        end
                    end
                end else begin
                    m_reject = sym_valid;
                    if (code_ack) m_mode = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("code", 64'(code), 64'(m_code));
            chk("code_valid", 64'(code_valid), 64'(m_mode == 2));
            chk("active_p", 64'(active_p), 64'(m_player));
            chk("busy", 64'(busy), 64'(m_mode != 0));
            chk("digit_cnt", 64'(digit_cnt), 64'(q.size()));
            chk("sym_reject", 64'(sym_reject), 64'(m_reject));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic feed(input int v);
        sym_valid = 1'b1;
        sym_in = 3'(v);
        tick();
        sym_valid = 1'b0;
    endtask

    task automatic feed_b(input int v);
        b_sym_valid = 1'b1;
        b_sym_in = 2'(v);
        tick();
        b_sym_valid = 1'b0;
    endtask

    initial begin
        #12 reset = 1'b0;
        @(negedge clk);
        chk("rst_code", 64'(code), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_valid", 64'(code_valid), 64'h0);

        // Basic entry
        tick();
        start = 1'b1; player_sel = 1'b1;
        tick();
        start = 1'b0; player_sel = 1'b0;
        feed(5); feed(2); feed(7);
        @(negedge clk);
        chk("valid_before_last", 64'(code_valid), 64'h0);
        feed(0);
        @(negedge clk);
        chk("basic_code", 64'(code), 64'hAB8);
        chk("model_code", 64'(m_code), 64'hAB8);
        chk("basic_valid", 64'(code_valid), 64'h1);
        chk("basic_player", 64'(active_p), 64'h1);
        chk("basic_cnt", 64'(digit_cnt), 64'h4);

        // Hold DONE with stray strobes
        for (int i = 0; i < 10; i++) begin
            sym_valid = (i % 2 == 0);
            sym_in = 3'($urandom);
            tick();
            if (i == 4) begin
                @(negedge clk);
                chk("done_reject", 64'(sym_reject), 64'h1);
            end
        end
        sym_valid = 1'b0;
        @(negedge clk);
        chk("done_hold_code", 64'(code), 64'hAB8);
        code_ack = 1'b1;
        tick();
        code_ack = 1'b0;
        @(negedge clk);
        chk("ack_valid", 64'(code_valid), 64'h0);
        chk("ack_busy", 64'(busy), 64'h0);
        chk("ack_code_kept", 64'(code), 64'hAB8);

        // Async reset mid-entry
        start = 1'b1;
        tick();
        start = 1'b0;
        feed(3); feed(6);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("arst_code", 64'(code), 64'h0);
        chk("arst_cnt", 64'(digit_cnt), 64'h0);
        chk("arst_busy", 64'(busy), 64'h0);
        #1 reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        feed(1); feed(1); feed(1); feed(1);
        @(negedge clk);
        chk("ones_code", 64'(code), 64'h249);
        chk("ones_valid", 64'(code_valid), 64'h1);

        // Ack and start together in DONE
        code_ack = 1'b1; start = 1'b1;
        tick();
        code_ack = 1'b0;
        @(negedge clk);
        chk("collide_busy", 64'(busy), 64'h0);
        chk("collide_valid", 64'(code_valid), 64'h0);
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("rearm_busy", 64'(busy), 64'h1);
        chk("rearm_cnt", 64'(digit_cnt), 64'h0);

`ifdef CODE_NO_REPEAT_EN
        feed(4); feed(4);
        @(negedge clk);
        chk("norep_rej1", 64'(sym_reject), 64'h1);
        feed(1); feed(4);
        @(negedge clk);
        chk("norep_rej2", 64'(sym_reject), 64'h1);
        feed(2); feed(7);
        @(negedge clk);
        chk("norep_code", 64'(code), 64'h857);
        chk("norep_cnt", 64'(digit_cnt), 64'h4);
        chk("norep_valid", 64'(code_valid), 64'h1);
`else
        feed(4); feed(4); feed(4); feed(4);
        @(negedge clk);
        chk("rep_code", 64'(code), 64'h924);
        chk("rep_reject", 64'(sym_reject), 64'h0);
`endif
        code_ack = 1'b1;
        tick();
        code_ack = 1'b0;

        // Second configuration
        b_start = 1'b1; b_player_sel = 2'd3;
        tick();
        b_start = 1'b0;
        @(negedge clk);
        chk("b_oor_player", 64'(b_active_p), 64'h0);
        chk("b_busy", 64'(b_busy), 64'h1);
`ifndef CODE_NO_REPEAT_EN
        feed_b(3); feed_b(2); feed_b(1); feed_b(0); feed_b(3); feed_b(2);
        @(negedge clk);
        chk("b_code", 64'(b_code), 64'hE4E);
        chk("b_valid", 64'(b_code_valid), 64'h1);
        chk("b_cnt", 64'(b_digit_cnt), 64'h6);
        b_code_ack = 1'b1;
        tick();
        b_code_ack = 1'b0;
        b_start = 1'b1; b_player_sel = 2'd2;
        tick();
        b_start = 1'b0;
        @(negedge clk);
        chk("b_player2", 64'(b_active_p), 64'h2);
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                #1 reset = 1'b0;
            end
            start      = ($urandom_range(0, 3) == 0);
            player_sel = 1'($urandom);
            sym_in     = 3'($urandom);
            sym_valid  = 1'($urandom);
            code_ack   = ($urandom_range(0, 3) == 0);
        end
        tick();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
